// File: rtl/ones_comp_csum_stream.sv
// Streaming ones'-complement checksum generator/checker with valid/ready framing.
// Optional macro CSUM_NORM_ZERO_EN presents an all-ones (negative zero) sum as zero.
module ones_comp_csum_stream #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] csum,
  output logic             check_ok,
  output logic [CNT_W-1:0] word_cnt,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] acc, acc_next;
  logic [WIDTH:0]   add_full;
  logic [CNT_W-1:0] cnt_next;
  logic [WIDTH-1:0] sum_d, csum_d;
  logic             accept;

  assign in_ready  = (state != DONE) && !rst;
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  // The end-around carry cannot overflow again: the widest add_full is 2^(WIDTH+1)-2.
  assign add_full = {1'b0, acc} + {1'b0, in_data};
  assign acc_next = add_full[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, add_full[WIDTH]};

  assign cnt_next = (word_cnt == {CNT_W{1'b1}}) ? word_cnt
                                                : word_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef CSUM_NORM_ZERO_EN
  assign sum_d  = (acc_next == {WIDTH{1'b1}}) ? {WIDTH{1'b0}} : acc_next;
  assign csum_d = ~sum_d;
`else
  assign sum_d  = acc_next;
  assign csum_d = ~acc_next;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE, ACCUM: begin
        if (accept) state_next = in_last ? DONE : ACCUM;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Results are captured with the in_last word so they are registered the cycle DONE begins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      word_cnt <= '0;
      sum      <= '0;
      csum     <= '1;
      check_ok <= 1'b0;
    end else begin
      state <= state_next;
      if (state == DONE && out_ready) begin
        acc      <= '0;
        word_cnt <= '0;
      end else if (accept) begin
        acc      <= acc_next;
        word_cnt <= cnt_next;
      end
      if (accept && in_last) begin
        sum      <= sum_d;
        csum     <= csum_d;
        check_ok <= (acc_next == {WIDTH{1'b1}});
      end
    end
  end

endmodule

// File: tb/tb_ones_comp_csum_stream.sv
// Scoreboard-based bench for ones_comp_csum_stream (WIDTH=4, CNT_W=8).
// Honours CSUM_NORM_ZERO_EN in its reference model when the build defines it.
module tb_ones_comp_csum_stream;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] c;
    logic             ok;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] csum;
  logic             check_ok;
  logic [CNT_W-1:0] word_cnt;
  logic             out_valid;
  logic             out_ready;

  int   checks;
  int   errors;
  exp_t sb[$];

  ones_comp_csum_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .sum(sum), .csum(csum), .check_ok(check_ok), .word_cnt(word_cnt),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] oc_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] t;
    t = {1'b0, a} + {1'b0, b};
    return t[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, t[WIDTH]};
  endfunction

  function automatic exp_t make_exp(input logic [WIDTH-1:0] raw, input logic [CNT_W-1:0] n);
    exp_t e;
`ifdef CSUM_NORM_ZERO_EN
    e.s = (raw == 4'hF) ? 4'h0 : raw;
`else
    e.s = raw;
`endif
    e.c   = ~e.s;
    e.ok  = (raw == 4'hF);
    e.cnt = n;
    return e;
  endfunction

  task automatic send_word(input logic [WIDTH-1:0] d, input logic last);
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Words are packed nibble 0 first; the expected result is queued as the frame is driven.
  task automatic drive_frame(input int n, input logic [15:0] words);
    logic [WIDTH-1:0] a;
    a = '0;
    for (int i = 0; i < n; i++) a = oc_add(a, words[4*i +: 4]);
    sb.push_back(make_exp(a, CNT_W'(n)));
    for (int i = 0; i < n; i++) send_word(words[4*i +: 4], (i == n - 1));
  endtask

  task automatic release_results;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if ({sum, csum, check_ok, word_cnt, out_valid, in_ready} !== {4'h0, 4'hF, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_values: got %h expected %h",
               {sum, csum, check_ok, word_cnt, out_valid, in_ready}, {4'h0, 4'hF, 1'b0, 8'h00, 1'b0, 1'b0});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL idle_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_basic;
    exp_t e, got;
    logic [15:0] frames [3];
    frames[0] = 16'h0035;
    frames[1] = 16'h001F;
    frames[2] = 16'h0089;
    for (int f = 0; f < 3; f++) begin
      drive_frame(2, frames[f]);
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL basic_latency[%0d]: out_valid %b expected 1", f, out_valid);
      end
      e = sb.pop_front();
      got = {sum, csum, check_ok, word_cnt};
      checks++;
      if (got !== e) begin
        errors++;
        $display("[TB] FAIL basic_result[%0d]: got %h expected %h", f, got, e);
      end
      release_results();
    end
  endtask

  task automatic test_checker;
    exp_t e, got;
    drive_frame(3, 16'h0735);
    e = sb.pop_front();
    got = {sum, csum, check_ok, word_cnt};
    checks++;
    if (out_valid !== 1'b1 || got !== e) begin
      errors++;
      $display("[TB] FAIL checker_frame: got %b/%h expected 1/%h", out_valid, got, e);
    end
    release_results();
  endtask

  task automatic test_backpressure;
    exp_t e, got;
    drive_frame(2, 16'h006C);
    e = sb.pop_front();
    in_valid = 1'b1;
    in_data  = 4'h9;
    for (int i = 0; i < 5; i++) begin
      got = {sum, csum, check_ok, word_cnt};
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || got !== e) begin
        errors++;
        $display("[TB] FAIL backpressure_hold[%0d]: got v=%b r=%b %h expected v=1 r=0 %h",
                 i, out_valid, in_ready, got, e);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    release_results();
    checks++;
    if ({out_valid, in_ready, word_cnt, dut.acc} !== {1'b0, 1'b1, 8'h00, 4'h0}) begin
      errors++;
      $display("[TB] FAIL backpressure_idle: got %h expected %h",
               {out_valid, in_ready, word_cnt, dut.acc}, {1'b0, 1'b1, 8'h00, 4'h0});
    end
    checks++;
    if (sum !== e.s) begin
      errors++;
      $display("[TB] FAIL backpressure_sum_held: got %h expected %h", sum, e.s);
    end
    drive_frame(1, 16'h0002);
    e = sb.pop_front();
    got = {sum, csum, check_ok, word_cnt};
    checks++;
    if (out_valid !== 1'b1 || got !== e) begin
      errors++;
      $display("[TB] FAIL backpressure_next: got %b/%h expected 1/%h", out_valid, got, e);
    end
    release_results();
  endtask

  task automatic test_gapped;
    exp_t e, got;
    sb.push_back(make_exp(oc_add(oc_add(4'h4, 4'h4), 4'h4), 8'd3));
    send_word(4'h4, 1'b0);
    in_last = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    in_last = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || word_cnt !== 8'd1) begin
      errors++;
      $display("[TB] FAIL gapped_hold: got v=%b cnt=%0d expected v=0 cnt=1", out_valid, word_cnt);
    end
    send_word(4'h4, 1'b0);
    send_word(4'h4, 1'b1);
    e = sb.pop_front();
    got = {sum, csum, check_ok, word_cnt};
    checks++;
    if (out_valid !== 1'b1 || got !== e) begin
      errors++;
      $display("[TB] FAIL gapped_result: got %b/%h expected 1/%h", out_valid, got, e);
    end
    release_results();
  endtask

  task automatic test_saturation;
    exp_t e, got;
    logic [WIDTH-1:0] a;
    a = '0;
    for (int i = 0; i < 260; i++) a = oc_add(a, 4'h1);
    sb.push_back(make_exp(a, 8'hFF));
    for (int i = 0; i < 260; i++) send_word(4'h1, (i == 259));
    e = sb.pop_front();
    got = {sum, csum, check_ok, word_cnt};
    checks++;
    if (out_valid !== 1'b1 || got !== e) begin
      errors++;
      $display("[TB] FAIL saturation: got %b/%h expected 1/%h", out_valid, got, e);
    end
    release_results();
  endtask

  task automatic test_reset_mid_frame;
    exp_t e, got;
    send_word(4'h7, 1'b0);
    send_word(4'h6, 1'b0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, sum, csum, word_cnt, in_ready} !== {1'b0, 4'h0, 4'hF, 8'h00, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_mid_frame: got %h expected %h",
               {out_valid, sum, csum, word_cnt, in_ready}, {1'b0, 4'h0, 4'hF, 8'h00, 1'b0});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    drive_frame(1, 16'h0001);
    e = sb.pop_front();
    got = {sum, csum, check_ok, word_cnt};
    checks++;
    if (out_valid !== 1'b1 || got !== e) begin
      errors++;
      $display("[TB] FAIL reset_next_frame: got %b/%h expected 1/%h", out_valid, got, e);
    end
    release_results();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    #12;
    test_reset();
    test_basic();
    test_checker();
    test_backpressure();
    test_gapped();
    test_saturation();
    test_reset_mid_frame();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
